// File: rtl/stack_unit_if.sv
// rtl/stack_unit_if.sv - request/response and DataMemory bus bundle for stack_unit
interface stack_unit_if #(
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int CW = 7
);
    // control-unit side
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          valid;
    logic          ready;
    logic          err;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    // DataMemory side
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic [DW-1:0] mem_out;

    // Stack controller view
    modport slave (
        input  push, pop, din, mem_out,
        output dout, valid, ready, err, full, empty, count,
               mem_en, mem_addr, mem_in
    );

    // Control unit plus DataMemory view
    modport master (
        output push, pop, din, mem_out,
        input  dout, valid, ready, err, full, empty, count,
               mem_en, mem_addr, mem_in
    );
endinterface

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - downward-growing operand stack controller in front of DataMemory
module stack_unit #(
    parameter int          AW         = 9,
    parameter int          DW         = 16,
    parameter logic [AW-1:0] STACK_BASE = 9'h1FF,
    parameter int          DEPTH      = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    stack_unit_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD      = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_t;

    // registered state
    state_t        r_state;
    logic [AW-1:0] r_sp;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_dout;
    logic          r_valid;
    logic          r_err;
    logic          r_mem_en;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_in;

    // next-state values
    state_t        w_state_nxt;
    logic [AW-1:0] w_sp_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [DW-1:0] w_dout_nxt;
    logic          w_valid_nxt;
    logic          w_err_nxt;
    logic          w_mem_en_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_mem_in_nxt;

    // status decoded from registered state only
    logic          w_full;
    logic          w_empty;
    logic          w_ready;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_ready = (r_state == ST_IDLE);

    // Register every output and the stack bookkeeping; async reset clears mid-write enables at once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_sp       <= STACK_BASE;
            r_count    <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_in   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sp       <= w_sp_nxt;
            r_count    <= w_count_nxt;
            r_dout     <= w_dout_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_in   <= w_mem_in_nxt;
        end
    end

    // Next-state and output decode; requests are only looked at in IDLE
    always_comb begin
        w_state_nxt    = r_state;
        w_sp_nxt       = r_sp;
        w_count_nxt    = r_count;
        w_dout_nxt     = r_dout;
        w_valid_nxt    = 1'b0;
        w_err_nxt      = 1'b0;
        w_mem_en_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_in_nxt   = r_mem_in;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.push && bus.pop) begin
                    // ambiguous request: reject without touching anything
                    w_err_nxt = 1'b1;
                end else if (bus.push) begin
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_WR;
                        w_mem_en_nxt   = 1'b1;
                        w_mem_addr_nxt = r_sp;
                        w_mem_in_nxt   = bus.din;
                    end
                end else if (bus.pop) begin
                    if (w_empty) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        // top of stack sits one above the free slot SP points at
                        w_state_nxt    = ST_RD;
                        w_mem_addr_nxt = r_sp + AW'(1);
                    end
                end
            end

            ST_WR: begin
                // memory captures the write on this edge
                w_state_nxt = ST_IDLE;
                w_sp_nxt    = r_sp - AW'(1);
                w_count_nxt = r_count + CW'(1);
            end

            ST_RD: begin
                // give DataMemory a full cycle for read data to settle
                w_state_nxt = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                w_state_nxt = ST_IDLE;
                w_dout_nxt  = bus.mem_out;
                w_valid_nxt = 1'b1;
                w_sp_nxt    = r_sp + AW'(1);
                w_count_nxt = r_count - CW'(1);
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.dout     = r_dout;
    assign bus.valid    = r_valid;
    assign bus.ready    = w_ready;
    assign bus.err      = r_err;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.mem_en   = r_mem_en;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_in   = r_mem_in;
endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - randomized self-checking bench for stack_unit with a queue reference model
module tb_stack_unit;
    localparam int AW  = 9;
    localparam int DW  = 16;
    localparam int CW  = 7;
    localparam int CAP = 64;

    logic clk;
    logic rst;

    stack_unit_if #(.AW(AW), .DW(DW), .CW(CW)) bus();

    stack_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    // DataMemory model: synchronous write, asynchronous read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) mem[bus.mem_addr] <= bus.mem_in;
    end
    assign bus.mem_out = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: a plain LIFO of pushed values and the last popped value
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_flags();
        check("full",  bus.full,  (model_q.size() == CAP) ? 1 : 0);
        check("empty", bus.empty, (model_q.size() == 0)   ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        exp_dout = '0;
    endtask

    task automatic do_push(input logic [DW-1:0] v, input bit hold_in_wr);
        int n;
        n = model_q.size();
        check("push_ready_in", bus.ready, 1);
        bus.push = 1'b1;
        bus.pop  = 1'b0;
        bus.din  = v;
        @(negedge clk);
        if (n == CAP) begin
            check("ovf_err",   bus.err,    1);
            check("ovf_memen", bus.mem_en, 0);
            check("ovf_count", bus.count,  CAP);
            check("ovf_ready", bus.ready,  1);
            bus.push = 1'b0;
            @(negedge clk);
            check("ovf_err_pulse", bus.err, 0);
        end else begin
            check("wr_memen", bus.mem_en,   1);
            check("wr_addr",  bus.mem_addr, 32'(9'h1FF) - n);
            check("wr_data",  bus.mem_in,   v);
            check("wr_ready", bus.ready,    0);
            check("wr_err",   bus.err,      0);
            check("wr_valid", bus.valid,    0);
            if (!hold_in_wr) bus.push = 1'b0;
            @(negedge clk);
            bus.push = 1'b0;
            model_q.push_back(v);
            check("push_ready_out", bus.ready,  1);
            check("push_memen_off", bus.mem_en, 0);
            check("push_err",       bus.err,    0);
            check("push_count",     bus.count,  model_q.size());
        end
        check_flags();
    endtask

    task automatic do_pop();
        int n;
        n = model_q.size();
        check("pop_ready_in", bus.ready, 1);
        bus.pop  = 1'b1;
        bus.push = 1'b0;
        @(negedge clk);
        if (n == 0) begin
            check("unf_err",   bus.err,    1);
            check("unf_dout",  bus.dout,   exp_dout);
            check("unf_memen", bus.mem_en, 0);
            check("unf_count", bus.count,  0);
            bus.pop = 1'b0;
            @(negedge clk);
            check("unf_err_pulse", bus.err, 0);
        end else begin
            check("rd_ready", bus.ready,  0);
            check("rd_memen", bus.mem_en, 0);
            check("rd_err",   bus.err,    0);
            check("rd_valid", bus.valid,  0);
            bus.pop = 1'b0;
            @(negedge clk);
            check("rdw_ready", bus.ready,  0);
            check("rdw_valid", bus.valid,  0);
            check("rdw_memen", bus.mem_en, 0);
            @(negedge clk);
            exp_dout = model_q.pop_back();
            check("pop_valid", bus.valid, 1);
            check("pop_dout",  bus.dout,  exp_dout);
            check("pop_count", bus.count, model_q.size());
            check("pop_ready", bus.ready, 1);
        end
        check_flags();
    endtask

    task automatic do_conflict();
        int n;
        n = model_q.size();
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        bus.din  = 16'($urandom);
        @(negedge clk);
        check("both_err",   bus.err,    1);
        check("both_memen", bus.mem_en, 0);
        check("both_count", bus.count,  n);
        check("both_ready", bus.ready,  1);
        check("both_dout",  bus.dout,   exp_dout);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(negedge clk);
        check("both_err_pulse", bus.err, 0);
    endtask

    initial begin
        logic [DW-1:0] saved;
        int r;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        bus.din  = '0;
        exp_dout = '0;

        // reset state
        rst = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", bus.ready,  1);
        check("rst_empty", bus.empty,  1);
        check("rst_full",  bus.full,   0);
        check("rst_count", bus.count,  0);
        check("rst_dout",  bus.dout,   0);
        check("rst_memen", bus.mem_en, 0);
        check("rst_addr",  bus.mem_addr, 0);
        check("rst_valid", bus.valid,  0);
        check("rst_err",   bus.err,    0);
        rst = 1'b0;
        model_q.delete();

        // directed push/pop of signed operands
        do_push(16'sd456, 1'b0);
        do_push(-16'sd7, 1'b0);
        check("two_count", bus.count, 2);
        do_pop();
        check("pop1_neg7", bus.dout, 16'hFFF9);
        do_pop();
        check("pop2_456", bus.dout, 16'd456);

        // underflow and conflict when empty
        do_pop();
        do_conflict();

        // fill to capacity, overflow, then drain in LIFO order
        for (int i = 0; i < CAP; i++) do_push(16'($urandom), (i % 9) == 3);
        check("fill_full", bus.full, 1);
        do_push(16'h7FFF, 1'b0);
        do_conflict();
        for (int i = 0; i < CAP; i++) do_pop();
        do_pop();

        // randomized mix
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 52)      do_push(16'($urandom), $urandom_range(0, 7) == 0);
            else if (r < 88) do_pop();
            else if (r < 94) do_conflict();
            else begin
                @(negedge clk);
                check("idle_valid", bus.valid, 0);
                check("idle_err",   bus.err,   0);
                check("idle_count", bus.count, model_q.size());
            end
        end

        // reset in the middle of a write aborts it
        do_reset();
        saved = mem[9'h1FF];
        bus.din  = ~saved;
        bus.push = 1'b1;
        @(negedge clk);
        check("abort_wr_memen", bus.mem_en, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_memen_now", bus.mem_en, 0);
        check("abort_count",     bus.count,  0);
        check("abort_ready",     bus.ready,  1);
        bus.push = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        exp_dout = '0;
        check("abort_mem_kept", mem[9'h1FF], saved);

        // reset in the middle of a pop: no VALID, DOUT cleared
        do_push(16'h1234, 1'b0);
        do_push(16'hBEEF, 1'b0);
        do_pop();
        check("pre_abort_dout", bus.dout, 16'hBEEF);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_pop_dout",  bus.dout,  0);
        check("abort_pop_valid", bus.valid, 0);
        @(negedge clk);
        check("abort_pop_valid2", bus.valid, 0);
        check("abort_pop_count",  bus.count, 0);
        rst = 1'b0;
        model_q.delete();
        exp_dout = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
